// File: rtl/memory_writeback_stage_pkg.sv
// memory_writeback_stage_pkg: shared widths, result-select codes and FSM encoding
package memory_writeback_stage_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam logic RESULT_SRC_ALU = 1'b0;
   localparam logic RESULT_SRC_MEM = 1'b1;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/memory_writeback_stage_data_memory.sv
// data_memory: word-addressed data RAM, synchronous write, asynchronous read
module data_memory
   import memory_writeback_stage_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/memory_writeback_stage.sv
// memory_writeback_stage: data-memory access and MEM/WB register with optional multi-cycle latency
module memory_writeback_stage
   import memory_writeback_stage_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int MEM_LATENCY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrtMem,
   input  logic              MemWrtMem,
   input  logic              ResultSrcMem,
   input  logic [REG_W-1:0]  RD_Mem,
   input  logic [DATA_W-1:0] PCplus4Mem,
   input  logic [DATA_W-1:0] WriteDataMem,
   input  logic [DATA_W-1:0] ALU_ResultMem,
   output logic              RegWrtW,
   output logic [REG_W-1:0]  RD_W,
   output logic [DATA_W-1:0] PCplus4W,
   output logic [DATA_W-1:0] ResultW,
   output logic              StallMem
);
   localparam int ADDR_W = $clog2(DEPTH);
   logic              access, complete, stall;
   logic [DATA_W-1:0] rdata;
   logic              regwrt_q, regwrt_d, src_q;
   logic [REG_W-1:0]  rd_q;
   logic [DATA_W-1:0] pc_q, alu_q, rdata_q;
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{ALU_ResultMem[DATA_W-1:ADDR_W+2], ALU_ResultMem[1:0]};
   assign access = MemWrtMem | ResultSrcMem;
   data_memory #(.DEPTH(DEPTH)) u_mem (
      .clk  (clk),
      .we   (MemWrtMem & complete),
      .addr (ALU_ResultMem[ADDR_W+1:2]),
      .wdata(WriteDataMem),
      .rdata(rdata)
   );
   generate
      if (MEM_LATENCY == 0) begin : g_single
         assign complete = 1'b1;
         assign stall    = 1'b0;
      end else begin : g_multi
         localparam int CNT_W = $clog2(MEM_LATENCY + 1);
         state_e           state_q, state_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             last;
         assign last = cnt_q == CNT_W'(1);
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         always_comb begin
            state_d = (state_q == IDLE) ? (access ? BUSY : IDLE) : (last ? IDLE : BUSY);
            cnt_d   = (state_q == IDLE) ? (access ? CNT_W'(MEM_LATENCY) : '0) : cnt_q - 1'b1;
         end
         always_comb begin
            stall    = (state_q == IDLE) ? access : ~last;
            complete = (state_q == IDLE) ? ~access : last;
         end
      end
   endgenerate
   // Non-completing edges load a bubble: only the write enable drops, the rest holds
   assign regwrt_d = RegWrtMem & complete;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         regwrt_q <= 1'b0;
         src_q    <= RESULT_SRC_ALU;
         rd_q     <= '0;
         pc_q     <= '0;
         alu_q    <= '0;
         rdata_q  <= '0;
      end else begin
         regwrt_q <= regwrt_d;
         if (complete) begin
            src_q   <= ResultSrcMem;
            rd_q    <= RD_Mem;
            pc_q    <= PCplus4Mem;
            alu_q   <= ALU_ResultMem;
            rdata_q <= rdata;
         end
      end
   assign RegWrtW  = regwrt_q;
   assign RD_W     = rd_q;
   assign PCplus4W = pc_q;
   assign ResultW  = (src_q == RESULT_SRC_MEM) ? rdata_q : alu_q;
   assign StallMem = stall & ~rst;
endmodule

// File: tb/tb_memory_writeback_stage.sv
// tb_memory_writeback_stage: scoreboard bench for the single-cycle and two-cycle-latency variants
module tb_memory_writeback_stage;
   typedef struct packed {
      logic        rw, mw, src;
      logic [4:0]  rd;
      logic [31:0] pc, wd, alu;
   } ex_t;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] pc, res;
   } sb_t;
   logic clk = 1'b0, rst0 = 1'b0, rst2 = 1'b0;
   ex_t in0 = '0, in2 = '0;
   logic        o0_rw, o2_rw, o0_st, o2_st;
   logic [4:0]  o0_rd, o2_rd;
   logic [31:0] o0_pc, o2_pc, o0_res, o2_res;
   sb_t q0[$], q2[$];
   sb_t e0, e2;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   memory_writeback_stage #(.DEPTH(1024), .MEM_LATENCY(0)) dut0 (
      .clk(clk), .rst(rst0), .RegWrtMem(in0.rw), .MemWrtMem(in0.mw), .ResultSrcMem(in0.src),
      .RD_Mem(in0.rd), .PCplus4Mem(in0.pc), .WriteDataMem(in0.wd), .ALU_ResultMem(in0.alu),
      .RegWrtW(o0_rw), .RD_W(o0_rd), .PCplus4W(o0_pc), .ResultW(o0_res), .StallMem(o0_st)
   );
   memory_writeback_stage #(.DEPTH(1024), .MEM_LATENCY(2)) dut2 (
      .clk(clk), .rst(rst2), .RegWrtMem(in2.rw), .MemWrtMem(in2.mw), .ResultSrcMem(in2.src),
      .RD_Mem(in2.rd), .PCplus4Mem(in2.pc), .WriteDataMem(in2.wd), .ALU_ResultMem(in2.alu),
      .RegWrtW(o2_rw), .RD_W(o2_rd), .PCplus4W(o2_pc), .ResultW(o2_res), .StallMem(o2_st)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   task automatic chk_zero(input string tag, input int inst);
      chk({tag, "_rw"},  inst == 0 ? 32'(o0_rw) : 32'(o2_rw), 0);
      chk({tag, "_rd"},  inst == 0 ? 32'(o0_rd) : 32'(o2_rd), 0);
      chk({tag, "_pc"},  inst == 0 ? o0_pc : o2_pc, 0);
      chk({tag, "_res"}, inst == 0 ? o0_res : o2_res, 0);
      chk({tag, "_st"},  inst == 0 ? 32'(o0_st) : 32'(o2_st), 0);
   endtask
   // Drive one instruction; for a latency-2 memory access, hold it for all three cycles
   task automatic issue(input int inst, input ex_t e, input logic [31:0] res);
      @(negedge clk);
      if (inst == 0) in0 = e; else in2 = e;
      if (e.rw) begin
         if (inst == 0) q0.push_back('{e.rd, e.pc, res});
         else q2.push_back('{e.rd, e.pc, res});
      end
      #1;
      if (inst == 0) chk("stall0_off", 32'(o0_st), 0);
      else if (!(e.mw | e.src)) chk("stall2_alu", 32'(o2_st), 0);
      else begin
         chk("stall2_c0", 32'(o2_st), 1);
         @(negedge clk);
         chk("stall2_c1", 32'(o2_st), 1);
         chk("bubble2_c1", 32'(o2_rw), 0);
         @(negedge clk);
         chk("stall2_c2", 32'(o2_st), 0);
         chk("bubble2_c2", 32'(o2_rw), 0);
      end
   endtask
   always @(negedge clk)
      if (!rst0 && o0_rw) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb0_unexpected: got rd=%0d res=%h, expected no write-back", o0_rd, o0_res);
         end else begin
            e0 = q0.pop_front();
            chk("wb0_rd", 32'(o0_rd), 32'(e0.rd));
            chk("wb0_pc", o0_pc, e0.pc);
            chk("wb0_res", o0_res, e0.res);
         end
      end
   always @(negedge clk)
      if (!rst2 && o2_rw) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb2_unexpected: got rd=%0d res=%h, expected no write-back", o2_rd, o2_res);
         end else begin
            e2 = q2.pop_front();
            chk("wb2_rd", 32'(o2_rd), 32'(e2.rd));
            chk("wb2_pc", o2_pc, e2.pc);
            chk("wb2_res", o2_res, e2.res);
         end
      end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      #1 rst0 = 1'b1; rst2 = 1'b1;
      #1 chk_zero("reset0", 0);
      chk_zero("reset2", 2);
      @(negedge clk); @(negedge clk);
      rst0 = 1'b0; rst2 = 1'b0;
      // Single-cycle variant: store/load, ALU op, untouched word, wrap, load+store same word
      issue(0, ex_t'{1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, 32'h10}, 32'h0);
      issue(0, ex_t'{1'b1, 1'b0, 1'b1, 5'd5, 32'h104, 32'h0, 32'h10}, 32'hDEADBEEF);
      issue(0, ex_t'{1'b1, 1'b0, 1'b0, 5'd3, 32'h108, 32'h0, 32'h12345678}, 32'h12345678);
      issue(0, ex_t'{1'b1, 1'b0, 1'b1, 5'd4, 32'h10C, 32'h0, 32'h12345678}, 32'h0);
      issue(0, ex_t'{1'b0, 1'b1, 1'b0, 5'd0, 32'h110, 32'hA5, 32'h1004}, 32'h0);
      issue(0, ex_t'{1'b1, 1'b0, 1'b1, 5'd6, 32'h114, 32'h0, 32'h0004}, 32'hA5);
      issue(0, ex_t'{1'b1, 1'b1, 1'b1, 5'd7, 32'h118, 32'h11111111, 32'h10}, 32'hDEADBEEF);
      issue(0, ex_t'{1'b1, 1'b0, 1'b1, 5'd8, 32'h11C, 32'h0, 32'h10}, 32'h11111111);
      @(negedge clk);
      chk("pre_rst0_rw", 32'(o0_rw), 1);
      #2 rst0 = 1'b1;
      #1 chk_zero("async0", 0);
      in0 = '0;
      @(negedge clk) rst0 = 1'b0;
      // Latency-2 variant: store, back-to-back load, ALU op, reset mid-store, reload
      issue(2, ex_t'{1'b0, 1'b1, 1'b0, 5'd0, 32'h200, 32'hCAFE0001, 32'h20}, 32'h0);
      issue(2, ex_t'{1'b1, 1'b0, 1'b1, 5'd9, 32'h204, 32'h0, 32'h20}, 32'hCAFE0001);
      issue(2, ex_t'{1'b1, 1'b0, 1'b0, 5'd10, 32'h208, 32'h0, 32'h77}, 32'h77);
      @(negedge clk);
      in2 = ex_t'{1'b0, 1'b1, 1'b0, 5'd0, 32'h20C, 32'h55, 32'h40};
      #1 chk("rst_store_c0", 32'(o2_st), 1);
      @(negedge clk);
      chk("rst_store_c1", 32'(o2_st), 1);
      #2 rst2 = 1'b1;
      #1 chk_zero("async2", 2);
      in2 = '0;
      @(negedge clk) rst2 = 1'b0;
      issue(2, ex_t'{1'b1, 1'b0, 1'b1, 5'd11, 32'h210, 32'h0, 32'h40}, 32'h0);
      @(negedge clk) in2 = '0;
      @(negedge clk); @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 0);
      chk("q2_drained", 32'(q2.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/memory_writeback_stage.md
Name: memory_writeback_stage

Overview:
Consumer of the EX/MEM pipeline register. Performs the data-memory access for loads and stores, holds the MEM/WB pipeline register, and drives the write-back result. That result feeds the register file and the forwarding muxes. An optional multi-cycle memory latency is supported, and the block raises a stall request while an access is outstanding.

Parameters:
DEPTH, 1024, data memory size in 32-bit words (power of two); ADDR_W = log2(DEPTH) is derived locally.
MEM_LATENCY, 0, extra cycles per memory access; 0 means a single-cycle access with no stall.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
RegWrtMem  in  1  instruction in MEM writes the register file.
MemWrtMem  in  1  store.
ResultSrcMem  in  1  1 = load (result comes from memory), 0 = ALU result.
RD_Mem  in  5  destination register.
PCplus4Mem  in  32  PC+4, carried to WB.
WriteDataMem  in  32  store data, already forwarded upstream.
ALU_ResultMem  in  32  byte address, or ALU result.
RegWrtW  out  1  register-file write enable.
RD_W  out  5  write-back destination.
PCplus4W  out  32  PC+4 in WB.
ResultW  out  32  write-back data.
StallMem  out  1  request to freeze the PC, IF/ID, ID/EX and EX/MEM registers.

Behaviour:
- Reset (asynchronous, rst=1):
  - RegWrtW=0, RD_W=0, PCplus4W=0, ResultW=0, StallMem=0.
  - FSM goes to IDLE, counter=0.
  - Memory contents are not cleared; they are zero-initialised at simulation start.
- Addressing:
  - Word index is ALU_ResultMem[ADDR_W+1:2]; bits [1:0] are ignored.
  - Higher bits are discarded, so addresses wrap modulo DEPTH.
- Memory access:
  - Read is combinational.
  - Write is synchronous and occurs only on the completing edge (defined below).
  - access = MemWrtMem | ResultSrcMem.
- MEM/WB register:
  - Captures RegWrt, RD, PCplus4, ResultSrc, ALU result and read data on the completing edge.
  - ResultW = ResultSrcW ? ReadDataW : ALUResultW, both registered, so ResultW is a registered value.
  - Latency from the EX/MEM register to ResultW is 1 cycle when MEM_LATENCY=0.
- MEM_LATENCY=0:
  - StallMem is tied to 0.
  - Every edge is a completing edge.
- MEM_LATENCY=N>0: FSM with states IDLE and BUSY, plus a counter.
  - IDLE, access=0: completing edge; StallMem=0.
  - IDLE, access=1: StallMem=1. Next state is BUSY with cnt=N. On this edge MEM/WB loads a bubble (RegWrtW=0; other fields hold).
  - BUSY, cnt>1: StallMem=1, cnt decrements, bubble into WB.
  - BUSY, cnt==1: StallMem=0. This is the completing edge: the store is written or the load data is captured. Next state is IDLE.
  - Each access therefore occupies MEM for N+1 cycles.
  - Upstream must hold EX/MEM stable while StallMem=1; the block does not re-sample the instruction between the start and completion of an access.
- Back-to-back accesses: the next instruction arrives in IDLE, sees access=1 and starts a fresh sequence. The completing cycle is never reused as a start cycle.
- Reset during BUSY: the access is abandoned, no write occurs, and the FSM returns to IDLE.
- Store: RegWrtMem is expected to be 0 and is propagated as given. The block does no checking.
- Load with MemWrtMem=1 simultaneously: the write takes effect and ReadDataW captures the old (pre-write) word.

Decomposition:
- Shared pipeline package:
  - DATA_W=32, REG_W=5.
  - RESULT_SRC_ALU=1'b0, RESULT_SRC_MEM=1'b1.
  - FSM state encoding (IDLE=0, BUSY=1).
- Sub-module data_memory, parameterised on DEPTH:
  - Ports: clk, we, addr, wdata, rdata.
  - Synchronous write, asynchronous read, no reset.

Test Plan:
1. MEM_LATENCY=0; store 0xDEADBEEF at addr 0x10, then load addr 0x10 with RD=5, RegWrt=1 -> one cycle after the load, ResultW=0xDEADBEEF, RD_W=5, RegWrtW=1, StallMem always 0.
2. ALU op (ResultSrcMem=0, ALU_ResultMem=0x12345678, RD=3) -> next cycle ResultW=0x12345678, RegWrtW=1; memory unchanged at index 0x12345678[11:2].
3. MEM_LATENCY=2; load from 0x20 holding 0xCAFE0001 ->
   - StallMem is 1 for exactly 2 cycles, then 0 for 1 cycle.
   - RegWrtW=0 during the stall.
   - ResultW=0xCAFE0001 appears on the cycle after the completing edge.
4. MEM_LATENCY=2; store 0x55 to 0x40, assert rst during the first BUSY cycle, release, then load 0x40 -> the load returns the prior value 0x0; the FSM restarts from IDLE.
5. Address wrap with DEPTH=1024; store 0xA5 at addr 0x1004, then load addr 0x0004 -> ResultW=0xA5.
6. Reset asserted asynchronously mid-cycle with outputs nonzero -> RegWrtW, RD_W, PCplus4W, ResultW and StallMem go to 0 immediately, without waiting for a clock edge.
